// File: rtl/datapath_seq_pkg.sv
// rtl/datapath_seq_pkg.sv - shared state encoding, field widths and phase order for the datapath sequencer
package datapath_seq_pkg;

  localparam int STATE_W  = 3;
  localparam int ALU_OP_W = 3;
  localparam int SHIFT_W  = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_A = 3'd1,
    ST_LOAD_B = 3'd2,
    ST_EXEC   = 3'd3,
    ST_SHIFT  = 3'd4,
    ST_STORE  = 3'd5,
    ST_SHOW   = 3'd6
  } state_e;

  // IDLE is left once and never re-entered except through reset; SHOW wraps to LOAD_A
  function automatic state_e next_phase(input state_e s);
    state_e n;
    case (s)
      ST_IDLE:   n = ST_LOAD_A;
      ST_LOAD_A: n = ST_LOAD_B;
      ST_LOAD_B: n = ST_EXEC;
      ST_EXEC:   n = ST_SHIFT;
      ST_SHIFT:  n = ST_STORE;
      ST_STORE:  n = ST_SHOW;
      ST_SHOW:   n = ST_LOAD_A;
      default:   n = ST_IDLE;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - two-FF synchronizer, stability counter and rising-edge pulse for a board button
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clock,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic rise_pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;

  // The counter only runs while the synchronized input disagrees with the accepted level,
  // so any return to the old level reloads it.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync_q[1];
        rise_d  = sync_q[1];
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Level resets high so a button held through reset release never yields a rise
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      sync_q  <= 2'b00;
      cnt_q   <= '0;
      level_q <= 1'b1;
      rise_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_raw};
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
    end
  end

  assign level      = level_q;
  assign rise_pulse = rise_q;

endmodule

// File: rtl/datapath_sequencer.sv
// rtl/datapath_sequencer.sv - button-stepped phase FSM driving datapath load/shift pulses and controls
// Optional timer-driven advance when AUTO_RUN_EN is defined.
module datapath_sequencer
  import datapath_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000
`ifdef AUTO_RUN_EN
  ,
  parameter int AUTO_PERIOD = 50000000
`endif
) (
  input  logic                clock,
  input  logic                rst,
  input  logic                step_btn,
  input  logic [ALU_OP_W-1:0] op_sel,
  input  logic [SHIFT_W-1:0]  shift_sel,
`ifdef AUTO_RUN_EN
  input  logic                auto_mode,
`endif
  output logic                ena,
  output logic                enb,
  output logic                enshift,
  output logic                enc,
  output logic                select_mux,
  output logic [ALU_OP_W-1:0] ula_op,
  output logic [SHIFT_W-1:0]  shift_mode,
  output logic [STATE_W-1:0]  state_led,
  output logic                busy
);

  state_e              state_q, state_d;
  logic                ena_q, ena_d, enb_q, enb_d;
  logic                enshift_q, enshift_d, enc_q, enc_d;
  logic                select_mux_q, select_mux_d;
  logic [ALU_OP_W-1:0] ula_op_q, ula_op_d;
  logic [SHIFT_W-1:0]  shift_mode_q, shift_mode_d;
  logic                btn_level, btn_rise, step, advance, entering;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_step_debounce (
    .clock     (clock),
    .rst       (rst),
    .btn_raw   (step_btn),
    .level     (btn_level),
    .rise_pulse(btn_rise)
  );

  assign step = btn_rise & btn_level;

`ifdef AUTO_RUN_EN
  localparam int TMR_W = $clog2(AUTO_PERIOD);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(AUTO_PERIOD - 1);

  logic [TMR_W-1:0] timer_q, timer_d;
  logic             tick;

  assign tick    = auto_mode && (state_q != ST_IDLE) && (timer_q == TMR_LAST);
  assign advance = step | tick;

  // Any advance restarts the period, so a button step and an expiry in the same cycle count once
  always_comb begin
    timer_d = timer_q + TMR_W'(1);
    if (!auto_mode || (state_q == ST_IDLE) || advance) begin
      timer_d = '0;
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end
`else
  assign advance = step;
`endif

  always_comb begin
    state_d      = state_q;
    ula_op_d     = ula_op_q;
    shift_mode_d = shift_mode_q;
    case (state_q)
      ST_IDLE, ST_LOAD_A, ST_LOAD_B, ST_EXEC, ST_SHIFT, ST_STORE, ST_SHOW: begin
        if (advance) begin
          state_d = next_phase(state_q);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    entering     = (state_d != state_q);
    ena_d        = entering && (state_d == ST_LOAD_A);
    enb_d        = entering && (state_d == ST_LOAD_B);
    enshift_d    = entering && (state_d == ST_SHIFT);
    enc_d        = entering && (state_d == ST_STORE);
    select_mux_d = (state_d == ST_SHOW);
    if (entering && (state_d == ST_EXEC)) begin
      ula_op_d = op_sel;
    end
    if (entering && (state_d == ST_SHIFT)) begin
      shift_mode_d = shift_sel;
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      ena_q        <= 1'b0;
      enb_q        <= 1'b0;
      enshift_q    <= 1'b0;
      enc_q        <= 1'b0;
      select_mux_q <= 1'b0;
      ula_op_q     <= '0;
      shift_mode_q <= '0;
    end else begin
      state_q      <= state_d;
      ena_q        <= ena_d;
      enb_q        <= enb_d;
      enshift_q    <= enshift_d;
      enc_q        <= enc_d;
      select_mux_q <= select_mux_d;
      ula_op_q     <= ula_op_d;
      shift_mode_q <= shift_mode_d;
    end
  end

  assign ena        = ena_q;
  assign enb        = enb_q;
  assign enshift    = enshift_q;
  assign enc        = enc_q;
  assign select_mux = select_mux_q;
  assign ula_op     = ula_op_q;
  assign shift_mode = shift_mode_q;
  assign state_led  = state_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_datapath_sequencer.sv
// tb/tb_datapath_sequencer.sv - randomized self-checking bench for datapath_sequencer against a phase-level model
module tb_datapath_sequencer;

  localparam int DEB = 4;
  // raw press to visible state change: 2 sync + DEB stable samples + 1 FSM register
  localparam int LAT = DEB + 3;

  logic       clock = 1'b0;
  logic       rst = 1'b0;
  logic       step_btn = 1'b0;
  logic [2:0] op_sel = 3'b000;
  logic [1:0] shift_sel = 2'b00;
`ifdef AUTO_RUN_EN
  logic       auto_mode = 1'b0;
`endif
  logic       ena, enb, enshift, enc, select_mux, busy;
  logic [2:0] ula_op, state_led;
  logic [1:0] shift_mode;
  logic [13:0] dut_out;

  int checks = 0;
  int errors = 0;

  int         model_state;
  logic [2:0] model_ula;
  logic [1:0] model_shift;

  always #5 clock = ~clock;

  datapath_sequencer #(
    .DEBOUNCE_CYCLES(DEB)
`ifdef AUTO_RUN_EN
    , .AUTO_PERIOD(10)
`endif
  ) dut (
    .clock     (clock),
`ifdef AUTO_RUN_EN
    .auto_mode (auto_mode),
`endif
    .rst       (rst),
    .step_btn  (step_btn),
    .op_sel    (op_sel),
    .shift_sel (shift_sel),
    .ena       (ena),
    .enb       (enb),
    .enshift   (enshift),
    .enc       (enc),
    .select_mux(select_mux),
    .ula_op    (ula_op),
    .shift_mode(shift_mode),
    .state_led (state_led),
    .busy      (busy)
  );

  assign dut_out = {ena, enb, enshift, enc, select_mux, ula_op, shift_mode, state_led, busy};

  // phase order: IDLE, then LOAD_A..SHOW repeating
  function automatic int model_next(input int s);
    return (s == 0 || s == 6) ? 1 : s + 1;
  endfunction

  function automatic logic [13:0] model_outputs(input bit entry);
    logic [3:0] p;
    p = 4'b0000;
    if (entry) begin
      case (model_state)
        1: p = 4'b1000;
        2: p = 4'b0100;
        4: p = 4'b0010;
        5: p = 4'b0001;
        default: p = 4'b0000;
      endcase
    end
    return {p, (model_state == 6), model_ula, model_shift, 3'(model_state), (model_state != 0)};
  endfunction

  task automatic model_advance(input logic [2:0] op, input logic [1:0] sh);
    model_state = model_next(model_state);
    if (model_state == 3) model_ula = op;
    if (model_state == 4) model_shift = sh;
  endtask

  task automatic model_reset;
    model_state = 0;
    model_ula   = 3'b000;
    model_shift = 2'b00;
  endtask

  task automatic press(input logic [2:0] op, input logic [1:0] sh, input int gap);
    bit seen;
    int lat;
    op_sel = op;
    shift_sel = sh;
    step_btn = 1'b1;
    seen = 0;
    lat = 0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(posedge clock); #1;
      if (state_led != 3'(model_state)) begin
        seen = 1;
        lat = i;
      end else begin
        checks++;
        if (dut_out !== model_outputs(1'b0)) begin
          errors++;
          $display("FAIL press_wait got %b want %b", dut_out, model_outputs(1'b0));
        end
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL press_timeout state %0d never advanced", model_state);
    end else begin
      checks++;
      if (lat != LAT) begin
        errors++;
        $display("FAIL press_latency got %0d want %0d", lat, LAT);
      end
      model_advance(op, sh);
      checks++;
      if (dut_out !== model_outputs(1'b1)) begin
        errors++;
        $display("FAIL press_entry got %b want %b", dut_out, model_outputs(1'b1));
      end
    end
    step_btn = 1'b0;
    for (int i = 0; i < gap; i++) begin
      op_sel = 3'($urandom);
      shift_sel = 2'($urandom);
      @(posedge clock); #1;
      checks++;
      if (dut_out !== model_outputs(1'b0)) begin
        errors++;
        $display("FAIL press_hold got %b want %b", dut_out, model_outputs(1'b0));
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    step_btn = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (dut_out !== 14'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b want %b", dut_out, 14'b0);
    end
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < 12; i++) begin
      @(posedge clock); #1;
      checks++;
      if (dut_out !== model_outputs(1'b0)) begin
        errors++;
        $display("FAIL reset_idle got %b want %b", dut_out, model_outputs(1'b0));
      end
    end
  endtask

  task automatic test_sequence;
    logic [2:0] op;
    logic [1:0] sh;
    for (int i = 0; i < 7; i++) begin
      op = 3'($urandom);
      sh = 2'($urandom);
      if (model_state == 2) op = 3'b101;
      if (model_state == 3) sh = 2'b11;
      press(op, sh, 8);
    end
    op_sel = 3'b010;
    @(posedge clock); #1;
    checks++;
    if ({state_led, ula_op, shift_mode} !== {3'd1, 3'b101, 2'b11}) begin
      errors++;
      $display("FAIL sequence_wrap got %b want %b", {state_led, ula_op, shift_mode}, {3'd1, 3'b101, 2'b11});
    end
  endtask

  task automatic test_bounce(input bit rand_runs);
    int  elapsed;
    int  run;
    bit  lvl;
    elapsed = 0;
    lvl = 1'b0;
    while (elapsed < 20 || lvl) begin
      run = rand_runs ? int'($urandom_range(1, DEB - 1)) : 2;
      lvl = ~lvl;
      step_btn = lvl;
      for (int i = 0; i < run; i++) begin
        @(posedge clock); #1;
        checks++;
        if (dut_out !== model_outputs(1'b0)) begin
          errors++;
          $display("FAIL bounce_quiet got %b want %b", dut_out, model_outputs(1'b0));
        end
      end
      elapsed += run;
    end
    press(3'($urandom), 2'($urandom), 8);
  endtask

  task automatic test_reset_held;
    step_btn = 1'b1;
    rst = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < 25; i++) begin
      if (i == 15) step_btn = 1'b0;
      @(posedge clock); #1;
      checks++;
      if (dut_out !== model_outputs(1'b0)) begin
        errors++;
        $display("FAIL held_reset got %b want %b", dut_out, model_outputs(1'b0));
      end
    end
    press(3'($urandom), 2'($urandom), 8);
  endtask

  task automatic test_random;
    for (int i = 0; i < 14; i++) begin
      press(3'($urandom), 2'($urandom), int'($urandom_range(7, 15)));
    end
  endtask

  task automatic test_async_reset;
    bit seen;
    while (model_state != 4) begin
      press(3'($urandom) | 3'b001, 2'($urandom) | 2'b01, 8);
    end
    step_btn = 1'b1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clock); #1;
      if (enc === 1'b1) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL async_enc_timeout no enc pulse");
    end else begin
      model_advance(op_sel, shift_sel);
      checks++;
      if (dut_out !== model_outputs(1'b1)) begin
        errors++;
        $display("FAIL async_store_entry got %b want %b", dut_out, model_outputs(1'b1));
      end
    end
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    checks++;
    if (dut_out !== 14'b0) begin
      errors++;
      $display("FAIL async_reset_now got %b want %b", dut_out, 14'b0);
    end
    @(posedge clock); #1;
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) step_btn = 1'b0;
      @(posedge clock); #1;
      checks++;
      if (dut_out !== model_outputs(1'b0)) begin
        errors++;
        $display("FAIL async_idle got %b want %b", dut_out, model_outputs(1'b0));
      end
    end
    press(3'($urandom), 2'($urandom), 8);
  endtask

`ifdef AUTO_RUN_EN
  task automatic test_auto;
    bit seen;
    int n;
    int want;
    if (model_state == 0) press(3'($urandom), 2'($urandom), 8);
    auto_mode = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (k == 8) begin
        repeat (3) @(posedge clock);
        #1;
        step_btn = 1'b1;
      end
      want = (k == 8) ? 7 : 10;
      seen = 0;
      n = 0;
      for (int i = 1; i <= 30 && !seen; i++) begin
        @(posedge clock); #1;
        if (state_led != 3'(model_state)) begin
          seen = 1;
          n = i;
        end
      end
      step_btn = 1'b0;
      checks++;
      if (!seen || n != want) begin
        errors++;
        $display("FAIL auto_period got %0d want %0d", n, want);
      end
      model_advance(op_sel, shift_sel);
      checks++;
      if (dut_out !== model_outputs(1'b1)) begin
        errors++;
        $display("FAIL auto_entry got %b want %b", dut_out, model_outputs(1'b1));
      end
    end
    auto_mode = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clock); #1;
      checks++;
      if (dut_out !== model_outputs(1'b0)) begin
        errors++;
        $display("FAIL auto_off_hold got %b want %b", dut_out, model_outputs(1'b0));
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_sequence();
    test_bounce(1'b0);
    test_bounce(1'b1);
    test_reset_held();
    test_random();
    test_async_reset();
`ifdef AUTO_RUN_EN
    test_auto();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
